// File: rtl/can_pmod_phy_if.sv
// Pin-side conditioner between the on-chip CAN controller and the CAN PMOD transceiver:
// RX synchronise/glitch-filter with hard-sync edge pulse, TX register with stuck-dominant guard.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// ST_IDLE    | bus recessive from our side, core_txd passed through
// ST_DRIVE   | controller driving dominant, dcnt counts consecutive dominant cycles
// ST_BLOCKED | dominant timeout hit, TXD forced recessive until cleared
module can_pmod_phy_if #(
    parameter int FILTER_LEN  = 3,
    parameter int DOM_TIMEOUT = 4000,
    parameter int DOM_CNT_W   = 16
) (
    input  logic clk_sys,
    input  logic rst,
    input  logic core_txd,
    input  logic tx_enable,
    input  logic timeout_clr,
    output logic core_rxd,
    output logic rx_fall,
    output logic dom_timeout,
    output logic can_txd,
    input  logic can_rxd,
    output logic can_de,
    output logic can_re
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_DRIVE   = 2'd1;
    localparam logic [1:0] ST_BLOCKED = 2'd2;

    localparam logic [3:0]           FCNT_LAST = 4'(FILTER_LEN - 1);
    localparam logic [DOM_CNT_W-1:0] DCNT_MAX  = DOM_CNT_W'(DOM_TIMEOUT);

    logic                 sync1;
    logic                 sync2;
    logic [3:0]           fcnt;
    logic                 rxd_dly;

    logic [1:0]           state;
    logic [1:0]           state_nxt;
    logic [DOM_CNT_W-1:0] dcnt;
    logic [DOM_CNT_W-1:0] dcnt_nxt;
    logic                 txd_nxt;
    logic                 flag_nxt;

    // Receiver is always listening once out of reset.
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            can_re <= 1'b1;
        end else begin
            can_re <= 1'b0;
        end
    end

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= can_rxd;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            fcnt     <= 4'd0;
            core_rxd <= 1'b1;
        end else if (sync2 != core_rxd) begin
            if (fcnt >= FCNT_LAST) begin
                core_rxd <= sync2;
                fcnt     <= 4'd0;
            end else begin
                fcnt <= fcnt + 4'd1;
            end
        end else begin
            fcnt <= 4'd0;
        end
    end

    // Edge pulse lands in the cycle after core_rxd has fallen.
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            rxd_dly <= 1'b1;
            rx_fall <= 1'b0;
        end else begin
            rxd_dly <= core_rxd;
            rx_fall <= rxd_dly & ~core_rxd;
        end
    end

    // dcnt equals the number of dominant cycles already on can_txd, so the
    // guard trips after exactly DOM_TIMEOUT of them.
    always_comb begin
        state_nxt = state;
        dcnt_nxt  = dcnt;
        txd_nxt   = 1'b1;
        flag_nxt  = dom_timeout;
        case (state)
            ST_IDLE: begin
                txd_nxt  = core_txd;
                dcnt_nxt = '0;
                if (!core_txd) begin
                    state_nxt = ST_DRIVE;
                    dcnt_nxt  = DOM_CNT_W'(1);
                end
            end
            ST_DRIVE: begin
                if (core_txd) begin
                    state_nxt = ST_IDLE;
                    dcnt_nxt  = '0;
                    txd_nxt   = 1'b1;
                end else if (dcnt >= DCNT_MAX) begin
                    state_nxt = ST_BLOCKED;
                    txd_nxt   = 1'b1;
                    flag_nxt  = 1'b1;
                end else begin
                    dcnt_nxt = dcnt + DOM_CNT_W'(1);
                    txd_nxt  = 1'b0;
                end
            end
            ST_BLOCKED: begin
                txd_nxt = 1'b1;
                if (timeout_clr && core_txd) begin
                    state_nxt = ST_IDLE;
                    dcnt_nxt  = '0;
                    flag_nxt  = 1'b0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                dcnt_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            dcnt        <= '0;
            can_txd     <= 1'b1;
            dom_timeout <= 1'b0;
            can_de      <= 1'b0;
        end else begin
            state       <= state_nxt;
            dcnt        <= dcnt_nxt;
            can_txd     <= txd_nxt;
            dom_timeout <= flag_nxt;
            // Uses next state so the driver drops on the very cycle BLOCKED is entered.
            can_de      <= tx_enable & (state_nxt != ST_BLOCKED);
        end
    end

endmodule

// File: tb/tb_can_pmod_phy_if.sv
// Directed bench for can_pmod_phy_if with FILTER_LEN=3, DOM_TIMEOUT=8.
module tb_can_pmod_phy_if;

    logic clk_sys = 1'b0;
    logic rst;
    logic core_txd;
    logic tx_enable;
    logic timeout_clr;
    logic core_rxd;
    logic rx_fall;
    logic dom_timeout;
    logic can_txd;
    logic can_rxd;
    logic can_de;
    logic can_re;

    int n_checks = 0;
    int n_fail   = 0;

    can_pmod_phy_if #(
        .FILTER_LEN (3),
        .DOM_TIMEOUT(8),
        .DOM_CNT_W  (16)
    ) dut (
        .clk_sys    (clk_sys),
        .rst        (rst),
        .core_txd   (core_txd),
        .tx_enable  (tx_enable),
        .timeout_clr(timeout_clr),
        .core_rxd   (core_rxd),
        .rx_fall    (rx_fall),
        .dom_timeout(dom_timeout),
        .can_txd    (can_txd),
        .can_rxd    (can_rxd),
        .can_de     (can_de),
        .can_re     (can_re)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
        end
    endtask

    initial begin
        logic [3:0] pat;
        rst         = 1'b1;
        core_txd    = 1'b1;
        tx_enable   = 1'b0;
        timeout_clr = 1'b0;
        can_rxd     = 1'b1;

        // reset values
        step();
        step();
        chk("rst_core_rxd", core_rxd, 1'b1);
        chk("rst_rx_fall", rx_fall, 1'b0);
        chk("rst_dom_timeout", dom_timeout, 1'b0);
        chk("rst_can_txd", can_txd, 1'b1);
        chk("rst_can_de", can_de, 1'b0);
        chk("rst_can_re", can_re, 1'b1);

        rst = 1'b0;
        step();
        chk("rel_can_re", can_re, 1'b0);
        chk("rel_can_txd", can_txd, 1'b1);
        chk("rel_can_de", can_de, 1'b0);
        chk("rel_core_rxd", core_rxd, 1'b1);

        // 2-cycle glitch must be swallowed
        can_rxd = 1'b0;
        step();
        step();
        can_rxd = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("glitch_core_rxd", core_rxd, 1'b1);
            chk("glitch_rx_fall", rx_fall, 1'b0);
        end

        // falling edge: core_rxd low after 5 edges, pulse one cycle later
        can_rxd = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("fall_core_rxd_early", core_rxd, 1'b1);
            chk("fall_rx_fall_early", rx_fall, 1'b0);
        end
        step();
        chk("fall_core_rxd_5", core_rxd, 1'b0);
        chk("fall_rx_fall_5", rx_fall, 1'b0);
        step();
        chk("fall_rx_fall_pulse", rx_fall, 1'b1);
        step();
        chk("fall_rx_fall_end", rx_fall, 1'b0);
        chk("fall_core_rxd_held", core_rxd, 1'b0);

        // rising edge: follows after 5 edges, no pulse
        can_rxd = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step();
            chk("rise_core_rxd", core_rxd, (i >= 5) ? 1'b1 : 1'b0);
            chk("rise_rx_fall", rx_fall, 1'b0);
        end

        // TX pass-through 1,0,0,1
        tx_enable = 1'b1;
        step();
        chk("tx_can_de_on", can_de, 1'b1);
        pat = 4'b1001;
        for (int i = 3; i >= 0; i--) begin
            core_txd = pat[i];
            step();
            chk("tx_pass_can_txd", can_txd, pat[i]);
            chk("tx_pass_can_de", can_de, 1'b1);
        end

        // stuck dominant: 8 dominant cycles then blocked
        core_txd = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            step();
            chk("stuck_can_txd_dom", can_txd, 1'b0);
            chk("stuck_dom_timeout_low", dom_timeout, 1'b0);
            chk("stuck_can_de_on", can_de, 1'b1);
        end
        step();
        chk("blk_can_txd", can_txd, 1'b1);
        chk("blk_dom_timeout", dom_timeout, 1'b1);
        chk("blk_can_de", can_de, 1'b0);

        // clear while still dominant is ignored
        timeout_clr = 1'b1;
        step();
        timeout_clr = 1'b0;
        chk("clr_dom_ignored_flag", dom_timeout, 1'b1);
        chk("clr_dom_ignored_txd", can_txd, 1'b1);
        chk("clr_dom_ignored_de", can_de, 1'b0);
        core_txd = 1'b1;
        step();
        chk("blk_no_clr_flag", dom_timeout, 1'b1);
        chk("blk_no_clr_de", can_de, 1'b0);

        // recovery
        timeout_clr = 1'b1;
        step();
        timeout_clr = 1'b0;
        chk("rec_dom_timeout", dom_timeout, 1'b0);
        chk("rec_can_txd", can_txd, 1'b1);
        chk("rec_can_de", can_de, 1'b1);
        core_txd = 1'b0;
        step();
        chk("rec_dom_passes", can_txd, 1'b0);
        core_txd = 1'b1;
        step();
        chk("rec_rec_passes", can_txd, 1'b1);

        // collision: clear on the timeout edge loses
        core_txd = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            step();
            chk("col_can_txd_dom", can_txd, 1'b0);
        end
        timeout_clr = 1'b1;
        step();
        timeout_clr = 1'b0;
        chk("col_dom_timeout", dom_timeout, 1'b1);
        chk("col_can_txd", can_txd, 1'b1);
        chk("col_can_de", can_de, 1'b0);
        step();
        chk("col_still_blocked", dom_timeout, 1'b1);

        // asynchronous reset aborts immediately
        rst = 1'b1;
        #1;
        chk("arst_dom_timeout", dom_timeout, 1'b0);
        chk("arst_can_txd", can_txd, 1'b1);
        chk("arst_can_de", can_de, 1'b0);
        chk("arst_can_re", can_re, 1'b1);
        step();
        rst = 1'b0;
        core_txd = 1'b1;
        step();
        chk("arst_rel_can_de", can_de, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
